sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, cycles per 16-bit SRAM half-access; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  write request from MEM stage; held stable until ready.
REQ-005 SHALL have port rd_en  input  1  read request from MEM stage; held stable until ready.
REQ-006 SHALL have port address  input  32  byte address; word index = address[18:2].
REQ-007 SHALL have port write_data  input  32  store data.
REQ-008 SHALL have port read_data  output  32  load data; valid from the cycle ready completes a read.
REQ-009 SHALL have port ready  output  1  low = freeze pipeline; high = access complete or idle.
REQ-010 SHALL have port sram_addr  output  18  SRAM half-word address.
REQ-011 SHALL have port sram_dq_out  output  16  data driven to SRAM.
REQ-012 SHALL have port sram_dq_oe  output  1  high = drive sram_dq_out onto the bus.
REQ-013 SHALL have port sram_dq_in  input  16  data sampled from SRAM.
REQ-014 SHALL have port sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-015 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-016 IDLE with wr_en or rd_en SHALL go to LOW and latch index, operation and write_data; with neither, stay IDLE.
REQ-017 wr_en and rd_en asserted together SHALL perform a write only.
REQ-018 LOW SHALL drive sram_addr={idx,0} for WAIT_CYCLES cycles, then go to HIGH; HIGH SHALL drive {idx,1} for WAIT_CYCLES cycles, then go to DONE.
REQ-019 Writes SHALL drive sram_dq_out=write_data[15:0] in LOW and [31:16] in HIGH, with sram_dq_oe=1 and sram_we_n=0 throughout both states.
REQ-020 Reads SHALL keep sram_dq_oe=0 and sram_we_n=1, and capture sram_dq_in into read_data[15:0] on the last LOW cycle and into [31:16] on the last HIGH cycle.
REQ-021 DONE SHALL last one cycle, then go to IDLE.
REQ-022 ready SHALL be 1 in DONE and in IDLE with no request, and 0 otherwise (combinational on requests in IDLE).
REQ-023 Access latency SHALL be 2*WAIT_CYCLES+1 cycles from the accepting edge to DONE.
REQ-024 read_data SHALL hold its value until the next read captures new data; writes SHALL not alter it.
REQ-025 The wait counter SHALL reset to 0 on each state entry and compare against WAIT_CYCLES-1.
REQ-026 In states other than LOW and HIGH, sram_addr SHALL be 0, sram_we_n=1 and sram_dq_oe=0.

Reset
REQ-027 rst SHALL force IDLE, counter=0, read_data=0, sram_we_n=1 and sram_dq_oe=0 immediately, including mid-access; the aborted write is lost.

Configuration
REQ-028 With SRAM_POSTED_WRITE_EN defined, a write accepted in IDLE SHALL give ready=1 in that cycle, and HIGH SHALL return directly to IDLE, skipping DONE.
REQ-029 With SRAM_POSTED_WRITE_EN defined, while a posted write is in LOW/HIGH, ready SHALL equal !(rd_en|wr_en); a pending request SHALL be accepted in the next IDLE.
REQ-030 Without SRAM_POSTED_WRITE_EN, writes SHALL stall exactly like reads.

Structure
REQ-031 Package sram_pkg SHALL hold the state enum, SRAM_ADDR_W=18 and SRAM_DATA_W=16.
REQ-032 The wait counter SHALL be sub-module sram_wait_counter (inputs: clear, limit; output: expired).

Verification
REQ-033 Write 0xDEADBEEF to address 0x0000_0008, WAIT_CYCLES=1 -> sram_addr 4 with 0xBEEF, then 5 with 0xDEAD, sram_we_n=0 on both; ready=1 on the 3rd edge after accept.
REQ-034 SRAM model returns 0x1234 at address 4 and 0xABCD at address 5; read address 8 -> read_data=0xABCD1234 when ready rises.
REQ-035 WAIT_CYCLES=3, read -> ready low for 6 cycles after accept, high in the 7th.
REQ-036 rd_en=wr_en=1 -> write cycles only; sram_dq_oe=1; read_data unchanged.
REQ-037 rst asserted during HIGH of a write -> same-cycle sram_we_n=1, sram_dq_oe=0, read_data=0, state IDLE.
REQ-038 With SRAM_POSTED_WRITE_EN, write then an immediate read request -> ready=1 in the write-accept cycle, ready=0 until the write finishes, then the read completes after 2*WAIT_CYCLES+1 more cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared types and widths for the 32-bit-over-16-bit SRAM controller.
//   sram_state_t  : access sequencer states (IDLE, LOW, HIGH, DONE)
//   SRAM_ADDR_W   : SRAM half-word address width
//   SRAM_DATA_W   : SRAM data bus width
//   WAIT_CNT_W    : width of the per-half wait counter (WAIT_CYCLES <= 15)
// ---------------------------------------------------------------------------
package sram_pkg;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;
endpackage

// File: rtl/sram_wait_counter.sv
// ---------------------------------------------------------------------------
// sram_wait_counter
// Counts cycles spent in the current SRAM half-access.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart from 0 on the next edge (driven on every state change)
//   limit    : terminal count (WAIT_CYCLES-1)
//   expired  : high while the count equals limit, i.e. the last wait cycle
// ---------------------------------------------------------------------------
module sram_wait_counter
    import sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [WAIT_CNT_W-1:0] limit,
    output logic                  expired
);
    logic [WAIT_CNT_W-1:0] cnt;

    assign expired = (cnt == limit);

    // Saturates at limit so an idle controller never wraps the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
// Bridges 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as
// two half-word accesses (low half at {idx,0}, high half at {idx,1}), each
// lasting WAIT_CYCLES clocks. ready low freezes the pipeline.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, rd_en      : store / load request, held until ready (both = store)
//   address           : byte address, word index = address[18:2]
//   write_data        : store data
//   read_data         : load data, held until the next load completes
//   ready             : access complete or idle
//   sram_addr         : SRAM half-word address
//   sram_dq_out/oe    : write data and bus drive enable
//   sram_dq_in        : data from SRAM
//   sram_we_n         : write strobe, active low
//
// Optional feature: define SRAM_POSTED_WRITE_EN to post stores (ready in the
// accept cycle, no DONE state); a request arriving while the posted store is
// still on the bus stalls and is taken in the following IDLE cycle.
// ---------------------------------------------------------------------------
module sram_controller
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n
);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_CYCLES - 1);

    sram_state_t            state, state_next;
    logic                   op_wr;
    logic [SRAM_ADDR_W-2:0] idx;
    logic [31:0]            wdata;
    logic                   req;
    logic                   cnt_clear;
    logic                   cnt_expired;
    logic                   addr_unused;

    assign req         = wr_en | rd_en;
    assign addr_unused = &{1'b0, address[31:19], address[1:0]};

    sram_wait_counter u_wait (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .limit   (WAIT_LIMIT),
        .expired (cnt_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            idx       <= '0;
            wdata     <= '0;
            read_data <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req) begin
                op_wr <= wr_en;
                idx   <= address[18:2];
                wdata <= write_data;
            end
            if (!op_wr && cnt_expired) begin
                if (state == LOW)
                    read_data[15:0]  <= sram_dq_in;
                else if (state == HIGH)
                    read_data[31:16] <= sram_dq_in;
            end
        end
    end

    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        case (state)
            IDLE: begin
                ready = !req;
`ifdef SRAM_POSTED_WRITE_EN
                if (wr_en)
                    ready = 1'b1;
`endif
                if (req)
                    state_next = LOW;
            end
            LOW: begin
                sram_addr = {idx, 1'b0};
                if (op_wr) begin
                    sram_dq_out = wdata[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (cnt_expired)
                    state_next = HIGH;
            end
            HIGH: begin
                sram_addr = {idx, 1'b1};
                if (op_wr) begin
                    sram_dq_out = wdata[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (cnt_expired) begin
`ifdef SRAM_POSTED_WRITE_EN
                    state_next = op_wr ? IDLE : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

`ifdef SRAM_POSTED_WRITE_EN
        // The pipeline already moved past a posted store; only a new request stalls.
        if ((state == LOW || state == HIGH) && op_wr)
            ready = !req;
`endif

        // Restart the wait count on every state entry.
        cnt_clear = (state_next != state) || (state == IDLE) || (state == DONE);
    end
endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;
    localparam int W = 3;
`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    sram_controller #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM device model (plus a bench-side preload port)
    logic [15:0] sram_mem [0:1023] = '{default: 16'h0};
    logic        pre_en = 1'b0;
    logic [9:0]  pre_a  = '0;
    logic [15:0] pre_d  = '0;
    assign sram_dq_in = sram_mem[sram_addr[9:0]];
    always @(posedge clk) begin
        if (pre_en)          sram_mem[pre_a] <= pre_d;
        else if (!sram_we_n) sram_mem[sram_addr[9:0]] <= sram_dq_out;
    end

    // Reference model: word memory, last load value, and bus-availability time
    logic [31:0] ref_mem [0:511] = '{default: 32'h0};
    logic [31:0] last_rd = '0;
    int          free_at = 0;
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; int rdy_cyc; } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor: every completed request is compared against the queue head
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en | wr_en) begin
                if (ready) begin
                    if (sbq.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("sb_read_data", read_data, e.data);
                        chk("sb_ready_cycle", 32'(cyc), 32'(e.rdy_cyc));
                    end
                end
            end else begin
                chk("sb_idle_ready", {31'd0, ready}, 32'd1);
            end
        end
    end

    function automatic logic [31:0] mk_addr(input logic [8:0] widx);
        logic [31:0] a;
        a = $urandom;
        a[18:2] = {8'h0, widx};
        return a;
    endfunction

    // Random transaction: expectations pushed at issue, compared by the monitor
    task automatic issue(input logic rd, input logic wr, input logic [8:0] widx, input logic [31:0] wd);
        exp_t e;
        int   t, start, n;
        t = cyc;
        start = (free_at > t) ? free_at : t;
        if (wr && POSTED) begin
            e.rdy_cyc = start;
            free_at   = start + 2*W + 1;
        end else begin
            e.rdy_cyc = start + 2*W + 1;
            free_at   = e.rdy_cyc + 1;
        end
        if (wr) begin
            ref_mem[widx] = wd;
            e.data = last_rd;
        end else begin
            e.data  = ref_mem[widx];
            last_rd = e.data;
        end
        sbq.push_back(e);
        rd_en = rd; wr_en = wr; address = mk_addr(widx); write_data = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            n++;
            if (n > 200) begin
                $display("FAIL ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
                $fatal(1, "ready never rose");
            end
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    // Directed access with cycle-by-cycle pin checks; starts and ends with the DUT idle
    task automatic dir_access(input logic rd, input logic wr, input logic [8:0] widx,
                              input logic [31:0] wd, input logic [31:0] exp_rd);
        logic posted;
        logic [15:0] half;
        posted = wr && POSTED;
        rd_en = rd; wr_en = wr; address = mk_addr(widx); write_data = wd;
        @(negedge clk);
        chk("accept_ready", {31'd0, ready}, {31'd0, posted});
        @(posedge clk); #1;
        if (posted) begin rd_en = 1'b0; wr_en = 1'b0; end
        for (int k = 1; k <= 2*W; k++) begin
            @(negedge clk);
            half = (k > W) ? wd[31:16] : wd[15:0];
            chk("busy_ready", {31'd0, ready}, {31'd0, posted});
            chk("busy_addr", {14'd0, sram_addr}, 32'(widx) * 2 + ((k > W) ? 1 : 0));
            chk("busy_we_n", {31'd0, sram_we_n}, {31'd0, !wr});
            chk("busy_oe", {31'd0, sram_dq_oe}, {31'd0, wr});
            if (wr) chk("busy_dq_out", {16'd0, sram_dq_out}, {16'd0, half});
        end
        @(negedge clk);
        chk("done_ready", {31'd0, ready}, 32'd1);
        chk("done_addr", {14'd0, sram_addr}, 32'd0);
        chk("done_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("done_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("done_read_data", read_data, exp_rd);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Load from byte address 8 with halves 0x1234 / 0xABCD in the SRAM
        pre_en = 1'b1; pre_a = 10'd4; pre_d = 16'h1234;
        @(posedge clk); #1;
        pre_a = 10'd5; pre_d = 16'hABCD;
        @(posedge clk); #1;
        pre_en = 1'b0;
        ref_mem[2] = 32'hABCD1234;
        dir_access(1'b1, 1'b0, 9'd2, 32'h0, 32'hABCD1234);
        last_rd = 32'hABCD1234;

        // Store 0xDEADBEEF to byte address 8
        dir_access(1'b0, 1'b1, 9'd2, 32'hDEADBEEF, last_rd);
        ref_mem[2] = 32'hDEADBEEF;

        // Both requests set: store only, load data untouched
        dir_access(1'b1, 1'b1, 9'd3, 32'h55AA33CC, last_rd);
        ref_mem[3] = 32'h55AA33CC;
        dir_access(1'b1, 1'b0, 9'd3, 32'h0, 32'h55AA33CC);
        last_rd = 32'h55AA33CC;
        dir_access(1'b1, 1'b0, 9'd2, 32'h0, 32'hDEADBEEF);
        last_rd = 32'hDEADBEEF;

        // Reset during the high half of a store: low half landed, high half lost
        rd_en = 1'b0; wr_en = 1'b1; address = mk_addr(9'd5); write_data = 32'h11112222;
        @(posedge clk); #1;
        if (POSTED) wr_en = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        rst = 1'b1; wr_en = 1'b0;
        #1;
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("abort_read_data", read_data, 32'd0);
        chk("abort_addr", {14'd0, sram_addr}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        ref_mem[5] = {ref_mem[5][31:16], 16'h2222};
        last_rd = 32'd0;
        @(posedge clk); #1;
        dir_access(1'b1, 1'b0, 9'd5, 32'h0, ref_mem[5]);
        last_rd = ref_mem[5];

        // Randomized traffic through the scoreboard
        free_at = cyc;
        mon_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int op, gap;
            logic [8:0] widx;
            op   = $urandom_range(0, 9);
            gap  = $urandom_range(0, 2);
            widx = 9'($urandom_range(0, 15));
            if (op < 4)      issue(1'b1, 1'b0, widx, $urandom);
            else if (op < 8) issue(1'b0, 1'b1, widx, $urandom);
            else if (op < 9) issue(1'b1, 1'b1, widx, $urandom);
            else             issue(1'b1, 1'b0, widx, $urandom);
            repeat (gap) @(posedge clk);
            #1;
        end
        repeat (2*W + 2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
